// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StError
  } state_e;

  // A load into $0 never produces a value, so it can never cause a load-use stall.
  function automatic logic reg_dep(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return (dst != ZERO_REG) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hazard_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / control-flush decode plus a pipeline freeze for multi-cycle data-memory accesses,
// with a sticky timeout error and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RT_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS_i,
  input  logic [REG_ADDR_W-1:0] IFID_RT_i,
  input  logic                  Branch_taken_i,
  input  logic                  Jump_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  hazard_o,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  IFFlush_o,
  output logic                  pipe_stall_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             freeze, load_use, ctrl_flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = StMemWait;
          wait_d  = '0;
        end
      end
      StMemWait: begin
        if (mem_ack_i) begin
          state_d = StRun;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WaitW'(MEM_TIMEOUT)) begin
            state_d = StError;
          end
        end
      end
      StError: state_d = StError;
      default: state_d = StRun;
    endcase
  end

  assign freeze = ((state_q == StRun) && mem_req_i && !mem_ack_i) ||
                  ((state_q == StMemWait) && !mem_ack_i) ||
                  (state_q == StError);
  assign load_use = IDEX_MemRead_i &&
                    (reg_dep(IDEX_RT_i, IFID_RS_i) || reg_dep(IDEX_RT_i, IFID_RT_i));
  assign ctrl_flush = Branch_taken_i || Jump_i;

  // Mealy decode; reset forces the idle pattern whatever the inputs are.
  always_comb begin
    hazard_o     = 1'b0;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFFlush_o    = 1'b0;
    pipe_stall_o = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        pipe_stall_o = 1'b1;
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
      end else if (load_use) begin
        hazard_o    = 1'b1;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
      end else if (ctrl_flush) begin
        IFFlush_o = 1'b1;
      end
    end
  end

  assign err_o = (state_q == StError);

  hazard_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (!PCWrite_o),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (IFFlush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus a randomized run against a cycle-level model.
module tb_hazard_ctrl;

  localparam int unsigned MainTo  = 20;
  localparam int unsigned MainCnt = 8;
  localparam int          MainMax = 255;

  logic       clk = 1'b0;
  logic       rst, memread, br, jmp, req, ack;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic       haz, pcw, ifidw, ifl, pst, err;
  logic [7:0] scnt, fcnt;
  logic       t_haz, t_pcw, t_ifidw, t_ifl, t_pst, t_err;
  logic [3:0] t_scnt, t_fcnt;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: outstanding access, cycles waited, sticky error, performance counts.
  bit m_wait, m_err;
  int m_wcnt, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MainTo), .CNT_W(MainCnt)) dut (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memread), .IDEX_RT_i(idex_rt),
    .IFID_RS_i(ifid_rs), .IFID_RT_i(ifid_rt), .Branch_taken_i(br), .Jump_i(jmp),
    .mem_req_i(req), .mem_ack_i(ack), .hazard_o(haz), .PCWrite_o(pcw),
    .IFIDWrite_o(ifidw), .IFFlush_o(ifl), .pipe_stall_o(pst), .err_o(err),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(memread), .IDEX_RT_i(idex_rt),
    .IFID_RS_i(ifid_rs), .IFID_RT_i(ifid_rt), .Branch_taken_i(br), .Jump_i(jmp),
    .mem_req_i(req), .mem_ack_i(ack), .hazard_o(t_haz), .PCWrite_o(t_pcw),
    .IFIDWrite_o(t_ifidw), .IFFlush_o(t_ifl), .pipe_stall_o(t_pst), .err_o(t_err),
    .stall_cnt_o(t_scnt), .flush_cnt_o(t_fcnt)
  );

  // Expected {hazard, PCWrite, IFIDWrite, IFFlush, pipe_stall} for the current cycle.
  function automatic logic [4:0] exp_outs();
    bit frz, lu, fl;
    frz = m_err || (!ack && (m_wait || req));
    lu  = memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    fl  = br || jmp;
    if (rst) return 5'b01100;
    if (frz) return 5'b00001;
    if (lu)  return 5'b10000;
    if (fl)  return 5'b01110;
    return 5'b01100;
  endfunction

  // Advance one clock, updating the model from this cycle's inputs and expected outputs.
  task automatic tick();
    logic [4:0] o;
    o = exp_outs();
    if (rst) begin
      m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!o[3] && m_stall < MainMax) m_stall++;
      if (o[1] && m_flush < MainMax) m_flush++;
      if (!m_err) begin
        if (m_wait) begin
          if (ack) m_wait = 0;
          else begin
            m_wcnt++;
            if (m_wcnt == MainTo) begin m_err = 1; m_wait = 0; end
          end
        end else if (req && !ack) begin
          m_wait = 1; m_wcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    br = 0; jmp = 0; req = 0; ack = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    memread = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 0; br = 1; jmp = 0; req = 1; ack = 0;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw, ifidw, ifl, pst} !== 5'b01100) begin
      n_err++; $display("FAIL reset_outs got %b want 01100", {haz, pcw, ifidw, ifl, pst});
    end
    tick();
    rst = 0; clear_in();
    n_checks++;
    if ({scnt, fcnt, err, t_err, t_scnt} !== '0) begin
      n_err++; $display("FAIL reset_state got scnt=%0d fcnt=%0d err=%b t_err=%b t_scnt=%0d want 0",
                        scnt, fcnt, err, t_err, t_scnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    memread = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 3;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw, ifidw, ifl} !== 4'b1000) begin
      n_err++; $display("FAIL load_use got %b want 1000", {haz, pcw, ifidw, ifl});
    end
    tick();
    memread = 0;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw, scnt} !== {2'b01, 8'd1}) begin
      n_err++; $display("FAIL load_use_after got haz=%b pcw=%b scnt=%0d want 0 1 1", haz, pcw, scnt);
    end
    tick();
  endtask

  task automatic test_zero_nomatch();
    do_reset();
    memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw} !== 2'b01) begin
      n_err++; $display("FAIL zero_reg got haz=%b pcw=%b want 0 1", haz, pcw);
    end
    tick();
    idex_rt = 8; ifid_rs = 9; ifid_rt = 10;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw} !== 2'b01) begin
      n_err++; $display("FAIL no_match got haz=%b pcw=%b want 0 1", haz, pcw);
    end
    tick();
    n_checks++;
    if (scnt !== 8'd0) begin
      n_err++; $display("FAIL no_stall_cnt got %0d want 0", scnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    br = 1;
    @(negedge clk);
    n_checks++;
    if ({haz, pcw, ifidw, ifl} !== 4'b0111) begin
      n_err++; $display("FAIL branch_flush got %b want 0111", {haz, pcw, ifidw, ifl});
    end
    tick();
    n_checks++;
    if (fcnt !== 8'd1) begin
      n_err++; $display("FAIL flush_cnt got %0d want 1", fcnt);
    end
    memread = 1; idex_rt = 5; ifid_rs = 1; ifid_rt = 5;
    @(negedge clk);
    n_checks++;
    if ({haz, ifl} !== 2'b10) begin
      n_err++; $display("FAIL flush_vs_loaduse got haz=%b ifl=%b want 1 0", haz, ifl);
    end
    tick();
    memread = 0; br = 0; jmp = 1;
    @(negedge clk);
    n_checks++;
    if ({ifl, fcnt, scnt} !== {1'b1, 8'd1, 8'd1}) begin
      n_err++; $display("FAIL jump_flush got ifl=%b fcnt=%0d scnt=%0d want 1 1 1", ifl, fcnt, scnt);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    req = 1; ack = 1;
    @(negedge clk);
    n_checks++;
    if (pst !== 1'b0) begin
      n_err++; $display("FAIL single_cycle_mem got pst=%b want 0", pst);
    end
    tick();
    ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin memread = 1; idex_rt = 7; ifid_rs = 7; end
      else memread = 0;
      @(negedge clk);
      n_checks++;
      if ({haz, pcw, ifidw, pst} !== 4'b0001) begin
        n_err++; $display("FAIL mem_wait_%0d got %b want 0001", i, {haz, pcw, ifidw, pst});
      end
      tick();
    end
    memread = 0; ack = 1;
    @(negedge clk);
    n_checks++;
    if ({pcw, pst} !== 2'b10) begin
      n_err++; $display("FAIL mem_ack got pcw=%b pst=%b want 1 0", pcw, pst);
    end
    tick();
    req = 0; ack = 0;
    @(negedge clk);
    n_checks++;
    if ({pst, scnt} !== {1'b0, 8'd4}) begin
      n_err++; $display("FAIL mem_wait_cnt got pst=%b scnt=%0d want 0 4", pst, scnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (t_err !== 1'b0) begin
        n_err++; $display("FAIL timeout_early_%0d got err=%b want 0", k, t_err);
      end
      tick();
    end
    req = 0; ack = 1;
    @(negedge clk);
    n_checks++;
    if ({t_err, t_pst} !== 2'b11) begin
      n_err++; $display("FAIL timeout_err got err=%b pst=%b want 1 1", t_err, t_pst);
    end
    tick(); tick();
    n_checks++;
    if ({t_err, t_pst} !== 2'b11) begin
      n_err++; $display("FAIL error_sticky got err=%b pst=%b want 1 1", t_err, t_pst);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({t_err, t_pst, t_scnt, t_fcnt} !== 10'b0) begin
      n_err++; $display("FAIL timeout_reset got err=%b pst=%b scnt=%0d fcnt=%0d want 0",
                        t_err, t_pst, t_scnt, t_fcnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    memread = 1; idex_rt = 8; ifid_rs = 8;
    for (int i = 0; i < 20; i++) tick();
    memread = 0;
    n_checks++;
    if ({t_scnt, scnt} !== {4'd15, 8'd20}) begin
      n_err++; $display("FAIL saturation got t_scnt=%0d scnt=%0d want 15 20", t_scnt, scnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      memread = $urandom_range(0, 1);
      idex_rt = 5'($urandom_range(0, 3));
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      br      = ($urandom_range(0, 3) == 0);
      jmp     = ($urandom_range(0, 6) == 0);
      req     = ($urandom_range(0, 9) < 3);
      ack     = (c > 300) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      e = exp_outs();
      n_checks++;
      if ({haz, pcw, ifidw, ifl, pst} !== e || err !== m_err) begin
        n_err++; $display("FAIL rand_outs cyc %0d got %b err=%b want %b err=%b",
                          c, {haz, pcw, ifidw, ifl, pst}, err, e, m_err);
      end
      n_checks++;
      if (int'(scnt) != m_stall || int'(fcnt) != m_flush) begin
        n_err++; $display("FAIL rand_cnt cyc %0d got scnt=%0d fcnt=%0d want %0d %0d",
                          c, scnt, fcnt, m_stall, m_flush);
      end
      tick();
    end
    rst = 0; clear_in();
  endtask

  initial begin
    m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    clear_in();
    rst = 1;
    #1;
    test_reset();
    test_load_use();
    test_zero_nomatch();
    test_flush();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It drives the bubble-insert select of the ID-stage control-zeroing mux, the PC and IF/ID write enables, and the IF flush. It also freezes the whole pipeline while a multi-cycle data-memory access is outstanding. Saturating stall and flush counters are provided for performance measurement.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles spent in MEM_WAIT before the sticky error is raised.
- `CNT_W`, default 32: width of the performance counters.

Ports (`name  direction  width  meaning`):
- `clk_i  in  1`  single clock; all state updates on rising edge.
- `rst_i  in  1`  reset, synchronous, active-high.
- `IDEX_MemRead_i  in  1`  instruction in EX is a load.
- `IDEX_RT_i  in  5`  destination register of the load in EX.
- `IFID_RS_i  in  5`  source register of the instruction in ID.
- `IFID_RT_i  in  5`  source register of the instruction in ID.
- `Branch_taken_i  in  1`  branch resolved taken in ID.
- `Jump_i  in  1`  jump decoded in ID.
- `mem_req_i  in  1`  EX/MEM instruction accesses data memory.
- `mem_ack_i  in  1`  data memory completes the access this cycle.
- `hazard_o  out  1`  bubble select; 1 zeroes ID control signals.
- `PCWrite_o  out  1`  PC update enable.
- `IFIDWrite_o  out  1`  IF/ID register write enable.
- `IFFlush_o  out  1`  clear IF/ID to NOP.
- `pipe_stall_o  out  1`  freeze all pipeline registers and PC.
- `err_o  out  1`  sticky memory-timeout error.
- `stall_cnt_o  out  CNT_W`  number of cycles with `PCWrite_o`=0.
- `flush_cnt_o  out  CNT_W`  number of cycles with `IFFlush_o`=1.

## Operation
State machine, three states:
- **RUN**
  - Goes to MEM_WAIT on `mem_req_i & !mem_ack_i`.
- **MEM_WAIT**
  - Goes to RUN on `mem_ack_i`.
  - Goes to ERROR when the wait counter reaches `MEM_TIMEOUT` without an ack.
- **ERROR**
  - Left only by reset.

Decode is Mealy (combinational from state and inputs), with the following priority, highest first.

1. **Memory freeze**
   - Active when `(RUN & mem_req_i & !mem_ack_i) | MEM_WAIT & !mem_ack_i | ERROR`.
   - Outputs: `pipe_stall_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0, `hazard_o`=0, `IFFlush_o`=0.
   - Load-use and flush conditions are ignored in this case.
2. **Load-use**
   - Active when `IDEX_MemRead_i`, `IDEX_RT_i`≠0, and `IDEX_RT_i` equals `IFID_RS_i` or `IFID_RT_i`.
   - Outputs: `hazard_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0, `IFFlush_o`=0.
   - A simultaneous branch or jump is not flushed. ID holds, and the branch is re-evaluated next cycle.
3. **Control flush**
   - Active when `Branch_taken_i | Jump_i`.
   - Outputs: `IFFlush_o`=1, `PCWrite_o`=1, `IFIDWrite_o`=1, `hazard_o`=0.
4. **Idle**
   - Outputs: `PCWrite_o`=1, `IFIDWrite_o`=1, all others 0.

Additional rules:
- Register $0 never creates a load-use hazard.
- A single-cycle memory (`mem_req_i` and `mem_ack_i` in the same cycle) causes no stall.
- The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without an ack.
- The stall and flush counters saturate at all-ones and never wrap.

## Timing
- **Reset values:** state RUN, wait counter 0, `err_o`=0, both performance counters 0.
- **During reset:** while `rst_i` is high, outputs are forced to the Idle values regardless of inputs.
- **Latency:** load-use stall and flush assert in the same cycle as the triggering inputs (zero latency). Load-use lasts exactly one cycle, because the load advances to MEM.
- **Memory ack:** the cycle in which `mem_ack_i` is seen has `pipe_stall_o`=0. The pipeline advances on that edge and the state returns to RUN.
- **Timeout:** `err_o` rises on the edge where the wait counter reaches `MEM_TIMEOUT`. ERROR keeps `pipe_stall_o`=1 until reset.
- **Reset mid-wait:** returns to RUN on the next edge and discards the outstanding access.
- **Counter updates:** counters update on the clock edge, based on the outputs of that cycle. A cycle with both freeze and load-use conditions counts once in `stall_cnt_o`.

## Structure
- **`hazard_pkg`** contains:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the `REG_ADDR_W`=5 constant;
  - the ZERO_REG constant.
- **`hazard_sat_cnt`** is the one natural sub-module: a `CNT_W` saturating counter with synchronous clear and an increment enable. It is instantiated twice, once for stalls and once for flushes.

## Test plan
- **Load-use:** `IDEX_MemRead_i`=1, `IDEX_RT_i`=8, `IFID_RS_i`=8 → one cycle with `hazard_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0; `stall_cnt_o` goes 0→1.
- **$0 and non-matching:** `IDEX_RT_i`=0 with `IFID_RS_i`=0, and `IDEX_RT_i`=8 with sources 9/10 → no stall; `stall_cnt_o` stays 0.
- **Flush:** `Branch_taken_i`=1 with no hazard → `IFFlush_o`=1, `PCWrite_o`=1; `flush_cnt_o`=1. Same cycle with a load-use match → `hazard_o`=1, `IFFlush_o`=0.
- **Memory wait:** `mem_req_i`=1, ack after 4 cycles → `pipe_stall_o`=1 for 4 cycles and 0 in the ack cycle; `stall_cnt_o`=4. A simultaneous load-use during the wait is suppressed (`hazard_o`=0).
- **Timeout:** `MEM_TIMEOUT`=3, no ack → `err_o`=1 after 3 wait cycles and `pipe_stall_o` stays 1. Pulsing `rst_i` → `err_o`=0, state RUN, counters 0.
- **Saturation:** `CNT_W`=4 with 20 stall cycles → `stall_cnt_o` holds at 15.
